and_or_op_arbiter: RTL and testbench

//   Shares one W-bit bitwise AND/OR unit between two requesters.

---
 rtl/and_or_op_arbiter_if.sv | 39 +++
 rtl/and_or_op_arbiter.sv | 143 ++++++++++++++
 tb/tb_and_or_op_arbiter.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/and_or_op_arbiter_if.sv
// Handshake bundle between two operand requesters, the shared AND/OR unit and
// its response consumer. The arbiter uses the slave view.
interface and_or_op_arbiter_if #(
  parameter int W = 7
);
  logic         req0_valid;
  logic         req0_ready;
  logic         req0_op;
  logic [W-1:0] req0_a;
  logic [W-1:0] req0_b;

  logic         req1_valid;
  logic         req1_ready;
  logic         req1_op;
  logic [W-1:0] req1_a;
  logic [W-1:0] req1_b;

  logic         rsp_valid;
  logic         rsp_ready;
  logic [W:0]   rsp_data;
  logic         rsp_id;
  logic         busy;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_data, rsp_id, busy
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_data, rsp_id, busy
  );
endinterface

// File: rtl/and_or_op_arbiter.sv
// Round-robin arbiter sharing one W-bit bitwise AND/OR unit between two
// requesters; one op in flight, result returned as {op, result} with its id.
module and_or_op_arbiter #(
  parameter int W           = 7,
  parameter int EXEC_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  and_or_op_arbiter_if.slave   bus
);

  localparam int              CNT_W    = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(EXEC_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next_state;

  logic [W-1:0]      r_a;
  logic [W-1:0]      r_b;
  logic              r_op;
  logic              r_id;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_last_grant;

  logic              r_rsp_valid;
  logic [W:0]        r_rsp_data;
  logic              r_rsp_id;

  logic              w_both;
  logic              w_any;
  logic              w_grant;
  logic              w_accept;
  logic              w_ready0;
  logic              w_ready1;
  logic              w_busy;
  logic              w_cnt_zero;
  logic [W-1:0]      w_result;

  // Grant goes to the lone valid requester, or away from the last winner on a tie.
  assign w_both     = bus.req0_valid & bus.req1_valid;
  assign w_any      = bus.req0_valid | bus.req1_valid;
  assign w_grant    = w_both ? ~r_last_grant : bus.req1_valid;
  assign w_cnt_zero = (r_cnt == '0);
  assign w_result   = r_op ? (r_a & r_b) : (r_a | r_b);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_ready0     = 1'b0;
    w_ready1     = 1'b0;
    w_accept     = 1'b0;
    w_busy       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ready0 = bus.req0_valid & ~w_grant;
        w_ready1 = bus.req1_valid &  w_grant;
        w_accept = w_any;
        if (w_any) begin
          w_next_state = S_EXEC;
        end
      end
      S_EXEC: begin
        w_busy = 1'b1;
        if (w_cnt_zero) begin
          w_next_state = S_RESP;
        end
      end
      S_RESP: begin
        w_busy = 1'b1;
        if (bus.rsp_ready) begin
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Reset is synchronous, so readys and busy are masked while rst_n is low.
  assign bus.req0_ready = rst_n & w_ready0;
  assign bus.req1_ready = rst_n & w_ready1;
  assign bus.busy       = rst_n & w_busy;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_data   = r_rsp_data;
  assign bus.rsp_id     = r_rsp_id;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a          <= '0;
      r_b          <= '0;
      r_op         <= 1'b0;
      r_id         <= 1'b0;
      r_cnt        <= '0;
      r_last_grant <= 1'b1;
      r_rsp_valid  <= 1'b0;
      r_rsp_data   <= '0;
      r_rsp_id     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a   <= w_grant ? bus.req1_a  : bus.req0_a;
        r_b   <= w_grant ? bus.req1_b  : bus.req0_b;
        r_op  <= w_grant ? bus.req1_op : bus.req0_op;
        r_id  <= w_grant;
        r_cnt <= CNT_LOAD;
      end

      if (r_state == S_EXEC) begin
        if (!w_cnt_zero) begin
          r_cnt <= r_cnt - 1'b1;
        end else begin
          r_rsp_data  <= {r_op, w_result};
          r_rsp_id    <= r_id;
          r_rsp_valid <= 1'b1;
        end
      end

      // The round-robin pointer only moves once the consumer has the result.
      if ((r_state == S_RESP) && bus.rsp_ready) begin
        r_rsp_valid  <= 1'b0;
        r_last_grant <= r_rsp_id;
      end
    end
  end

endmodule

// File: tb/tb_and_or_op_arbiter.sv
// Directed bench for and_or_op_arbiter: one instance with EXEC_CYCLES=1 and
// one with EXEC_CYCLES=3 for the mid-execution reset case.
module tb_and_or_op_arbiter;

  logic clk;
  logic rst_n;
  logic rst3_n;

  int errors = 0;
  int checks = 0;

  and_or_op_arbiter_if #(.W(7)) bus  ();
  and_or_op_arbiter_if #(.W(7)) bus3 ();

  and_or_op_arbiter #(.W(7), .EXEC_CYCLES(1)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  and_or_op_arbiter #(.W(7), .EXEC_CYCLES(3)) u_dut3 (
    .clk   (clk),
    .rst_n (rst3_n),
    .bus   (bus3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int last_t;

    rst_n  = 1'b0;
    rst3_n = 1'b0;
    bus.req0_valid = 1'b0; bus.req0_op = 1'b0; bus.req0_a = '0; bus.req0_b = '0;
    bus.req1_valid = 1'b0; bus.req1_op = 1'b0; bus.req1_a = '0; bus.req1_b = '0;
    bus.rsp_ready  = 1'b0;
    bus3.req0_valid = 1'b0; bus3.req0_op = 1'b0; bus3.req0_a = '0; bus3.req0_b = '0;
    bus3.req1_valid = 1'b0; bus3.req1_op = 1'b0; bus3.req1_a = '0; bus3.req1_b = '0;
    bus3.rsp_ready  = 1'b0;

    // Reset state, with a request pending that must not be acknowledged.
    tick();
    tick();
    bus.req0_valid = 1'b1;
    #1;
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    check("rst_rsp_data",  32'(bus.rsp_data),  32'h0);
    check("rst_rsp_id",    32'(bus.rsp_id),    32'h0);
    check("rst_busy",      32'(bus.busy),      32'h0);
    check("rst_ready0",    32'(bus.req0_ready), 32'h0);
    bus.req0_valid = 1'b0;

    // Single AND op from req0.
    rst_n = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_op = 1'b1; bus.req0_a = 7'h5A; bus.req0_b = 7'h3C;
    #1;
    check("t1_ready0", 32'(bus.req0_ready), 32'h1);
    check("t1_ready1", 32'(bus.req1_ready), 32'h0);
    tick();
    bus.req0_valid = 1'b0;
    #1;
    check("t1_exec_busy",  32'(bus.busy),      32'h1);
    check("t1_exec_valid", 32'(bus.rsp_valid), 32'h0);
    tick();
    check("t1_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    check("t1_rsp_data",  32'(bus.rsp_data),  32'h98);
    check("t1_rsp_id",    32'(bus.rsp_id),    32'h0);
    bus.rsp_ready = 1'b1;
    tick();
    check("t1_done_valid", 32'(bus.rsp_valid), 32'h0);
    check("t1_done_busy",  32'(bus.busy),      32'h0);
    check("t1_data_kept",  32'(bus.rsp_data),  32'h98);
    bus.rsp_ready = 1'b0;

    // Fresh reset, then both requesters valid together: req0 wins the first tie.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("t2_rst_data", 32'(bus.rsp_data), 32'h0);
    bus.req0_valid = 1'b1; bus.req0_op = 1'b0; bus.req0_a = 7'h41; bus.req0_b = 7'h02;
    bus.req1_valid = 1'b1; bus.req1_op = 1'b1; bus.req1_a = 7'h7F; bus.req1_b = 7'h0F;
    #1;
    check("t2_ready0", 32'(bus.req0_ready), 32'h1);
    check("t2_ready1", 32'(bus.req1_ready), 32'h0);
    tick();
    bus.req0_valid = 1'b0;
    #1;
    check("t2_exec_ready1", 32'(bus.req1_ready), 32'h0);
    tick();
    check("t2_rsp0_data",   32'(bus.rsp_data),   32'h43);
    check("t2_rsp0_id",     32'(bus.rsp_id),     32'h0);
    check("t2_rsp_ready1",  32'(bus.req1_ready), 32'h0);
    bus.rsp_ready = 1'b1;
    tick();
    check("t2_idle_ready1", 32'(bus.req1_ready), 32'h1);
    check("t2_idle_ready0", 32'(bus.req0_ready), 32'h0);
    tick();
    bus.req1_valid = 1'b0;
    tick();
    check("t2_rsp1_valid", 32'(bus.rsp_valid), 32'h1);
    check("t2_rsp1_data",  32'(bus.rsp_data),  32'h8F);
    check("t2_rsp1_id",    32'(bus.rsp_id),    32'h1);
    tick();
    check("t2_done_valid", 32'(bus.rsp_valid), 32'h0);
    bus.rsp_ready = 1'b0;

    // Both valid continuously, consumer always ready: ids alternate every 3 clocks.
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    bus.rsp_ready  = 1'b1;
    n = 0;
    last_t = 0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      tick();
      if (bus.rsp_valid) begin
        check("t3_rr_id", 32'(bus.rsp_id), 32'(n % 2));
        if (n > 0) check("t3_gap", 32'(c - last_t), 32'd3);
        last_t = c;
        n++;
      end
    end
    check("t3_count", 32'(n), 32'd4);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    tick();
    bus.rsp_ready = 1'b0;

    // Consumer stalls 5 cycles in RESP; req1 stays valid and is held off, not lost.
    bus.req0_valid = 1'b1; bus.req0_op = 1'b0; bus.req0_a = 7'h10; bus.req0_b = 7'h01;
    bus.req1_valid = 1'b1; bus.req1_op = 1'b1; bus.req1_a = 7'h33; bus.req1_b = 7'h55;
    #1;
    check("t4_ready0", 32'(bus.req0_ready), 32'h1);
    tick();
    bus.req0_valid = 1'b0;
    tick();
    for (int c = 0; c < 5; c++) begin
      check("t4_hold_valid",  32'(bus.rsp_valid),  32'h1);
      check("t4_hold_data",   32'(bus.rsp_data),   32'h11);
      check("t4_hold_id",     32'(bus.rsp_id),     32'h0);
      check("t4_hold_ready0", 32'(bus.req0_ready), 32'h0);
      check("t4_hold_ready1", 32'(bus.req1_ready), 32'h0);
      check("t4_hold_busy",   32'(bus.busy),       32'h1);
      tick();
    end
    bus.rsp_ready = 1'b1;
    tick();
    check("t4_release_valid",  32'(bus.rsp_valid),  32'h0);
    check("t4_release_ready1", 32'(bus.req1_ready), 32'h1);
    tick();
    bus.req1_valid = 1'b0;
    tick();
    check("t4_rsp1_data", 32'(bus.rsp_data), 32'h91);
    check("t4_rsp1_id",   32'(bus.rsp_id),   32'h1);
    tick();
    bus.rsp_ready = 1'b0;

    // Only req1 valid, back to back: never waits for req0.
    bus.req1_valid = 1'b1; bus.req1_op = 1'b0; bus.req1_a = 7'h0A; bus.req1_b = 7'h50;
    bus.rsp_ready  = 1'b1;
    #1;
    check("t6_ready1_first", 32'(bus.req1_ready), 32'h1);
    n = 0;
    last_t = 0;
    for (int c = 0; c < 40 && n < 3; c++) begin
      tick();
      if (bus.rsp_valid) begin
        check("t6_id",   32'(bus.rsp_id),   32'h1);
        check("t6_data", 32'(bus.rsp_data), 32'h5A);
        if (n > 0) check("t6_gap", 32'(c - last_t), 32'd3);
        last_t = c;
        n++;
      end
    end
    check("t6_count", 32'(n), 32'd3);
    bus.req1_valid = 1'b0;
    tick();
    bus.rsp_ready = 1'b0;

    // EXEC_CYCLES=3: reset mid-EXEC drops the op, next op is served normally.
    rst3_n = 1'b1;
    bus3.req0_valid = 1'b1; bus3.req0_op = 1'b1; bus3.req0_a = 7'h7F; bus3.req0_b = 7'h7F;
    tick();
    bus3.req0_valid = 1'b0;
    tick();
    check("t5_mid_busy",  32'(bus3.busy),      32'h1);
    check("t5_mid_valid", 32'(bus3.rsp_valid), 32'h0);
    rst3_n = 1'b0;
    bus3.req0_valid = 1'b1;
    #1;
    check("t5_rst_busy",   32'(bus3.busy),       32'h0);
    check("t5_rst_ready0", 32'(bus3.req0_ready), 32'h0);
    tick();
    rst3_n = 1'b1;
    bus3.req0_valid = 1'b0;
    bus3.rsp_ready  = 1'b1;
    #1;
    check("t5_post_busy", 32'(bus3.busy), 32'h0);
    for (int c = 0; c < 5; c++) begin
      check("t5_no_rsp", 32'(bus3.rsp_valid), 32'h0);
      tick();
    end
    bus3.req0_valid = 1'b1; bus3.req0_op = 1'b0; bus3.req0_a = 7'h21; bus3.req0_b = 7'h42;
    #1;
    check("t5_next_ready0", 32'(bus3.req0_ready), 32'h1);
    tick();
    bus3.req0_valid = 1'b0;
    tick();
    check("t5_lat_e1", 32'(bus3.rsp_valid), 32'h0);
    tick();
    check("t5_lat_e2", 32'(bus3.rsp_valid), 32'h0);
    tick();
    check("t5_lat_e3",  32'(bus3.rsp_valid), 32'h1);
    check("t5_rsp_data", 32'(bus3.rsp_data), 32'h63);
    check("t5_rsp_id",   32'(bus3.rsp_id),   32'h0);
    tick();
    check("t5_done_valid", 32'(bus3.rsp_valid), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
